// File: rtl/hold_grip_scanner.sv
`default_nettype none
// ============================================================================
// Module      : hold_grip_scanner
// Description : Per-frame grip detector. Keeps a table of world-space hold
//               positions and, on each frame_start_i, walks every entry
//               through a two-stage distance pipeline against both user hands
//               (translated from screen to world space). The lowest-index
//               valid hold strictly inside RADIUS_SQ is reported per hand.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   vclock, reset            clock and synchronous active-high reset
//   frame_start_i            one-cycle scan request (ignored while busy)
//   screenx_i/screeny_i      signed world position of the screen origin
//   hand{1,2}{x,y}_i         unsigned hand screen coordinates
//   grab{1,2}_i              hand closed flags
//   wr_*_i                   hold table write port (any state)
//   busy_o                   scan in progress (through the done cycle)
//   done_o                   one-cycle scan-complete pulse
//   hand{1,2}_held_o/_idx_o  grip result, idx is 0 when not held
// ============================================================================
module hold_grip_scanner #(
    parameter int NUM_HOLDS = 16,
    parameter int RADIUS_SQ = 150
) (
    input  logic               vclock,
    input  logic               reset,
    input  logic               frame_start_i,
    input  logic signed [11:0] screenx_i,
    input  logic signed [12:0] screeny_i,
    input  logic        [10:0] hand1x_i,
    input  logic        [9:0]  hand1y_i,
    input  logic        [10:0] hand2x_i,
    input  logic        [9:0]  hand2y_i,
    input  logic               grab1_i,
    input  logic               grab2_i,
    input  logic               wr_en_i,
    input  logic        [3:0]  wr_idx_i,
    input  logic signed [11:0] wr_x_i,
    input  logic signed [12:0] wr_y_i,
    input  logic               wr_valid_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               hand1_held_o,
    output logic        [3:0]  hand1_idx_o,
    output logic               hand2_held_o,
    output logic        [3:0]  hand2_idx_o
);

    localparam logic [3:0]  LAST_IDX    = 4'(NUM_HOLDS - 1);
    localparam logic [30:0] RADIUS_SQ_W = 31'(RADIUS_SQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Squared distance; products are formed at 30 bits so the sign extension
    // is explicit and the sum can never overflow the 31-bit result.
    function automatic logic [30:0] dist_sq(input logic signed [14:0] dx,
                                            input logic signed [14:0] dy);
        logic signed [29:0] ex;
        logic signed [29:0] ey;
        logic signed [29:0] sx;
        logic signed [29:0] sy;
        ex = {{15{dx[14]}}, dx};
        ey = {{15{dy[14]}}, dy};
        sx = ex * ex;
        sy = ey * ey;
        return {1'b0, sx} + {1'b0, sy};
    endfunction

    // ------------------------------------------------------------------
    // Hold table. The array is always 16 deep so the 4-bit index is exact;
    // entries at or beyond NUM_HOLDS are never written nor scanned.
    // ------------------------------------------------------------------
    logic signed [11:0] hold_x_q [16];
    logic signed [12:0] hold_y_q [16];
    logic        [15:0] hold_v_q;
    logic               wr_ok;

    assign wr_ok = wr_en_i && (int'(wr_idx_i) < NUM_HOLDS);

    // Positions carry no reset; validity lives in hold_v_q.
    always_ff @(posedge vclock) begin
        if (wr_ok) begin
            hold_x_q[wr_idx_i] <= wr_x_i;
            hold_y_q[wr_idx_i] <= wr_y_i;
        end
    end

    // ------------------------------------------------------------------
    // State and pipeline registers
    // ------------------------------------------------------------------
    state_t             state_q;
    logic        [3:0]  scan_idx_q;
    logic               busy_q;
    logic               done_q;
    logic signed [13:0] w1x_q, w1y_q, w2x_q, w2y_q;
    logic               grab1_q, grab2_q;

    // Stage A: differences for the entry read last cycle
    logic               a_vld_q;
    logic               a_valid_q;
    logic        [3:0]  a_idx_q;
    logic signed [14:0] a_dx1_q, a_dy1_q, a_dx2_q, a_dy2_q;

    // Stage B: qualified hit per hand
    logic               b_hit1_q, b_hit2_q;
    logic        [3:0]  b_idx_q;

    // Working match registers and their next state
    logic               m1_held_q, m2_held_q;
    logic        [3:0]  m1_idx_q, m2_idx_q;
    logic               m1_held_d, m2_held_d;
    logic        [3:0]  m1_idx_d, m2_idx_d;

    // Registered outputs
    logic               hand1_held_q, hand2_held_q;
    logic        [3:0]  hand1_idx_q, hand2_idx_q;

    // World hand coordinates: signed origin plus zero-extended screen offset
    logic signed [13:0] w1x_d, w1y_d, w2x_d, w2y_d;
    assign w1x_d = {{2{screenx_i[11]}}, screenx_i} + {3'b000, hand1x_i};
    assign w1y_d = {screeny_i[12], screeny_i} + {4'b0000, hand1y_i};
    assign w2x_d = {{2{screenx_i[11]}}, screenx_i} + {3'b000, hand2x_i};
    assign w2y_d = {screeny_i[12], screeny_i} + {4'b0000, hand2y_i};

    // Entry under scan; a same-cycle write lands after this read
    logic signed [11:0] cur_x;
    logic signed [12:0] cur_y;
    logic               cur_v;
    assign cur_x = hold_x_q[scan_idx_q];
    assign cur_y = hold_y_q[scan_idx_q];
    assign cur_v = hold_v_q[scan_idx_q];

    logic signed [14:0] dx1_d, dy1_d, dx2_d, dy2_d;
    assign dx1_d = {{3{cur_x[11]}}, cur_x} - {w1x_q[13], w1x_q};
    assign dy1_d = {{2{cur_y[12]}}, cur_y} - {w1y_q[13], w1y_q};
    assign dx2_d = {{3{cur_x[11]}}, cur_x} - {w2x_q[13], w2x_q};
    assign dy2_d = {{2{cur_y[12]}}, cur_y} - {w2y_q[13], w2y_q};

    logic hit1_d, hit2_d;
    assign hit1_d = a_vld_q && a_valid_q && grab1_q &&
                    (dist_sq(a_dx1_q, a_dy1_q) < RADIUS_SQ_W);
    assign hit2_d = a_vld_q && a_valid_q && grab2_q &&
                    (dist_sq(a_dx2_q, a_dy2_q) < RADIUS_SQ_W);

    // First match wins: once a hand is held, later hits are discarded
    always_comb begin
        m1_held_d = m1_held_q;
        m1_idx_d  = m1_idx_q;
        m2_held_d = m2_held_q;
        m2_idx_d  = m2_idx_q;
        if (b_hit1_q && !m1_held_q) begin
            m1_held_d = 1'b1;
            m1_idx_d  = b_idx_q;
        end
        if (b_hit2_q && !m2_held_q) begin
            m2_held_d = 1'b1;
            m2_idx_d  = b_idx_q;
        end
    end

    // The DONE state loads the registered outputs, so done_o/busy_o trail
    // the state register by one cycle; the IDLE cycle that carries done_o
    // still has busy_q set and therefore refuses a new frame_start_i.
    always_ff @(posedge vclock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            scan_idx_q   <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hold_v_q     <= '0;
            w1x_q        <= '0;
            w1y_q        <= '0;
            w2x_q        <= '0;
            w2y_q        <= '0;
            grab1_q      <= 1'b0;
            grab2_q      <= 1'b0;
            a_vld_q      <= 1'b0;
            a_valid_q    <= 1'b0;
            a_idx_q      <= 4'd0;
            a_dx1_q      <= '0;
            a_dy1_q      <= '0;
            a_dx2_q      <= '0;
            a_dy2_q      <= '0;
            b_hit1_q     <= 1'b0;
            b_hit2_q     <= 1'b0;
            b_idx_q      <= 4'd0;
            m1_held_q    <= 1'b0;
            m1_idx_q     <= 4'd0;
            m2_held_q    <= 1'b0;
            m2_idx_q     <= 4'd0;
            hand1_held_q <= 1'b0;
            hand1_idx_q  <= 4'd0;
            hand2_held_q <= 1'b0;
            hand2_idx_q  <= 4'd0;
        end else begin
            if (wr_ok) begin
                hold_v_q[wr_idx_i] <= wr_valid_i;
            end

            a_vld_q   <= 1'b0;
            b_hit1_q  <= hit1_d;
            b_hit2_q  <= hit2_d;
            b_idx_q   <= a_idx_q;
            m1_held_q <= m1_held_d;
            m1_idx_q  <= m1_idx_d;
            m2_held_q <= m2_held_d;
            m2_idx_q  <= m2_idx_d;
            done_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (frame_start_i) begin
                        w1x_q      <= w1x_d;
                        w1y_q      <= w1y_d;
                        w2x_q      <= w2x_d;
                        w2y_q      <= w2y_d;
                        grab1_q    <= grab1_i;
                        grab2_q    <= grab2_i;
                        m1_held_q  <= 1'b0;
                        m1_idx_q   <= 4'd0;
                        m2_held_q  <= 1'b0;
                        m2_idx_q   <= 4'd0;
                        scan_idx_q <= 4'd0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    a_vld_q   <= 1'b1;
                    a_valid_q <= cur_v;
                    a_idx_q   <= scan_idx_q;
                    a_dx1_q   <= dx1_d;
                    a_dy1_q   <= dy1_d;
                    a_dx2_q   <= dx2_d;
                    a_dy2_q   <= dy2_d;
                    if (scan_idx_q == LAST_IDX) begin
                        state_q <= S_FLUSH;
                    end else begin
                        scan_idx_q <= scan_idx_q + 4'd1;
                    end
                end
                S_FLUSH: begin
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    hand1_held_q <= m1_held_d;
                    hand1_idx_q  <= m1_held_d ? m1_idx_d : 4'd0;
                    hand2_held_q <= m2_held_d;
                    hand2_idx_q  <= m2_held_d ? m2_idx_d : 4'd0;
                    done_q       <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign hand1_held_o = hand1_held_q;
    assign hand1_idx_o  = hand1_idx_q;
    assign hand2_held_o = hand2_held_q;
    assign hand2_idx_o  = hand2_idx_q;

endmodule
`default_nettype wire

// File: doc/hold_grip_scanner.md
Name: hold_grip_scanner

Overview:
- Consumes the hold map written by the map-edit path and decides, once per frame, whether each user hand is gripping a hold.
- Holds a NUM_HOLDS-entry table of world-space hold positions, written through a single write port.
- On frame_start it scans every entry sequentially and compares it against both hands, translated to world space.
- Reports per-hand grip flag and hold index to the climber physics logic.

Parameters:
NUM_HOLDS, 16, table entries (max 16; index 4 bits)
RADIUS_SQ, 150, grip threshold on squared distance (strict less-than)

Ports:
vclock  in  1  clock
reset  in  1  synchronous, active-high
frame_start  in  1  one-cycle scan request
screenx  in  12 signed  world x of screen origin
screeny  in  13 signed  world y of screen origin
hand1x  in  11  hand 1 screen x (unsigned)
hand1y  in  10  hand 1 screen y (unsigned)
hand2x  in  11  hand 2 screen x
hand2y  in  10  hand 2 screen y
grab1  in  1  hand 1 closed
grab2  in  1  hand 2 closed
wr_en  in  1  table write strobe
wr_idx  in  4  entry to write
wr_x  in  12 signed  hold world x
wr_y  in  13 signed  hold world y
wr_valid  in  1  entry valid bit written with wr_x/wr_y
busy  out  1  scan in progress
done  out  1  one-cycle scan-complete pulse
hand1_held  out  1  hand 1 gripping
hand1_idx  out  4  hold index gripped by hand 1
hand2_held  out  1  hand 2 gripping
hand2_idx  out  4  hold index gripped by hand 2

Behaviour:
- Reset: all table valid bits cleared; busy=0, done=0, held flags=0, idx outputs=0; FSM to IDLE. Positions need not be cleared.
- Writes: on any cycle with wr_en=1, entry wr_idx takes {wr_valid, wr_x, wr_y}. Writes are accepted in any state. wr_idx >= NUM_HOLDS is ignored.
- FSM states: IDLE, SCAN, FLUSH, DONE.
- IDLE:
  - frame_start=1 latches world hand coordinates: wx = screenx + zero-extended hand x; wy = screeny + zero-extended hand y, both 14-bit signed.
  - Latches grab1/grab2 and clears the working match registers.
  - Goes to SCAN with scan index 0.
- SCAN:
  - One entry per cycle, index 0..NUM_HOLDS-1.
  - Stage A registers dx = hold_x - wx and dy = hold_y - wy (15-bit signed) for both hands, plus the entry valid bit.
  - Stage B computes d2 = dx*dx + dy*dy (31-bit unsigned) and tests d2 < RADIUS_SQ.
  - After the last index, go to FLUSH.
- FLUSH: one cycle draining stage B, then DONE.
- Match rule per hand:
  - The first (lowest-index) valid entry with d2 < RADIUS_SQ wins.
  - Later matches do not overwrite it.
  - A hand whose latched grab was 0 never matches.
- DONE:
  - hand outputs update from the working registers; idx=0 when not held.
  - done=1 for exactly this cycle; then IDLE.
- Latency: frame_start sampled at edge E0; done is high in the cycle after edge E0+NUM_HOLDS+2 (cycle 18 for 16 entries). Outputs hold their values until the next DONE.
- busy=1 from the cycle after the frame_start sample through the DONE cycle inclusive.
- frame_start while busy: ignored, not queued.
- Write to an entry in the same cycle it is read: the scanner sees the old value. Changes to already-scanned entries apply next frame.
- Reset mid-scan: immediate abort, all reset values apply, no done pulse.
- Inputs other than wr_* are sampled only at scan start. Changes mid-scan have no effect.

Test Plan:
- Entry 3 = (500,-200) valid; screen (100,-400); hand1 (405,195) grab1=1 → world (505,-205), d2=50 → hand1_held=1, hand1_idx=3. hand2 (0,0) → hand2_held=0, idx=0. done exactly one cycle, 18 cycles after the frame_start sample.
- Boundary: entry 0 = (0,0), screen origin 0; hand1 at (7,10) → d2=149, held. Hand1 at (12,3) → d2=153, not held.
- Overlap: entries 2 and 9 both within radius of hand2 with grab2=1 → hand2_idx=2. Clear entry 2 via wr_valid=0, rescan → hand2_idx=9.
- grab1=0 with hand exactly on a hold → hand1_held=0. An invalid entry at the hand position → not held.
- frame_start pulsed again at cycle 5 of a scan → ignored, single done pulse. Reset asserted at cycle 8 → busy=0, outputs 0, no done, table invalid.
- wr_idx=15 with NUM_HOLDS=8 → no entry altered. A write to entry 0 during the scan at index 10 → visible only on the next frame's result.
